// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if
// Bundles every signal of the decode-to-execute stage except clk/rst.
//   decode side   : id_valid/id_ready handshake plus decoded instruction fields
//   producers     : EX/MEM (exm_*) and MEM/WB (wb_*) forwarding sources
//   execute side  : ex_valid/ex_ready handshake, ALU operands d1/d2/control,
//                   ex_pc, ex_rd, ex_reg_write
// Modports: master = surrounding pipeline driving the stage, slave = the stage.
interface id_ex_stage_if;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [31:0] id_rs1_data;
   logic [31:0] id_rs2_data;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic [4:0]  id_rd;
   logic [31:0] id_imm;
   logic [3:0]  id_alu_ctrl;
   logic        id_use_pc;
   logic        id_use_imm;
   logic        id_reg_write;
   logic        flush;

   logic        exm_reg_write;
   logic [4:0]  exm_rd;
   logic [31:0] exm_result;
   logic        exm_is_load;
   logic        wb_reg_write;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] d1;
   logic [31:0] d2;
   logic [3:0]  control;
   logic [31:0] ex_pc;
   logic [4:0]  ex_rd;
   logic        ex_reg_write;

   modport master (
      output id_valid, id_pc, id_rs1_data, id_rs2_data, id_rs1, id_rs2, id_rd,
             id_imm, id_alu_ctrl, id_use_pc, id_use_imm, id_reg_write, flush,
             exm_reg_write, exm_rd, exm_result, exm_is_load,
             wb_reg_write, wb_rd, wb_data, ex_ready,
      input  id_ready, ex_valid, d1, d2, control, ex_pc, ex_rd, ex_reg_write
   );

   modport slave (
      input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_rs1, id_rs2, id_rd,
             id_imm, id_alu_ctrl, id_use_pc, id_use_imm, id_reg_write, flush,
             exm_reg_write, exm_rd, exm_result, exm_is_load,
             wb_reg_write, wb_rd, wb_data, ex_ready,
      output id_ready, ex_valid, d1, d2, control, ex_pc, ex_rd, ex_reg_write
   );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage
// One-entry decode-to-execute buffer for the RV32 core. Captures a decoded
// instruction, resolves operand forwarding from EX/MEM and MEM/WB, holds off
// execute on a load-use hazard and keeps held operands fresh while stalled.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - id_ex_stage_if.slave (decode, producer and execute signals)
//
// state   | meaning
// --------+---------------------------------------------------------
// S_EMPTY | no instruction held; id_ready=1
// S_FULL  | instruction held; presented to execute unless hazard
module id_ex_stage (
   input  logic          clk,
   input  logic          rst,
   id_ex_stage_if.slave  bus
);

   typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

   state_t      state_q, state_d;
   logic        full;
   logic        load;

   logic [31:0] pc_q;
   logic [31:0] rs1_data_q;
   logic [31:0] rs2_data_q;
   logic [4:0]  rs1_q;
   logic [4:0]  rs2_q;
   logic [4:0]  rd_q;
   logic [31:0] imm_q;
   logic [3:0]  ctrl_q;
   logic        use_pc_q;
   logic        use_imm_q;
   logic        reg_write_q;

   logic        exm_hit_rs1, exm_hit_rs2;
   logic        wb_hit_rs1, wb_hit_rs2;
   logic [31:0] fwd_rs1, fwd_rs2;
   logic        ld_match_rs1, ld_match_rs2;
   logic        hazard;
   logic        fire_out, fire_in;

   assign full = (state_q == S_FULL);

   // Forwarding: EX/MEM wins over WB; x0 is never forwarded.
   assign exm_hit_rs1 = bus.exm_reg_write && (bus.exm_rd == rs1_q) && (rs1_q != 5'd0);
   assign exm_hit_rs2 = bus.exm_reg_write && (bus.exm_rd == rs2_q) && (rs2_q != 5'd0);
   assign wb_hit_rs1  = bus.wb_reg_write  && (bus.wb_rd  == rs1_q) && (rs1_q != 5'd0);
   assign wb_hit_rs2  = bus.wb_reg_write  && (bus.wb_rd  == rs2_q) && (rs2_q != 5'd0);

   assign fwd_rs1 = exm_hit_rs1 ? bus.exm_result :
                    wb_hit_rs1  ? bus.wb_data    : rs1_data_q;
   assign fwd_rs2 = exm_hit_rs2 ? bus.exm_result :
                    wb_hit_rs2  ? bus.wb_data    : rs2_data_q;

   // A load in EX/MEM only has its address on exm_result, so a dependent
   // operand must wait for the WB stage to supply the loaded data.
   assign ld_match_rs1 = bus.exm_is_load && bus.exm_reg_write && (bus.exm_rd != 5'd0)
                         && (bus.exm_rd == rs1_q);
   assign ld_match_rs2 = bus.exm_is_load && bus.exm_reg_write && (bus.exm_rd != 5'd0)
                         && (bus.exm_rd == rs2_q);
   assign hazard = full && ((ld_match_rs1 && !use_pc_q) || (ld_match_rs2 && !use_imm_q));

   assign bus.ex_valid = full && !hazard;
   assign fire_out     = bus.ex_valid && bus.ex_ready;
   assign bus.id_ready = !full || fire_out;
   assign fire_in      = bus.id_valid && bus.id_ready && !bus.flush;

   assign bus.d1           = use_pc_q  ? pc_q  : fwd_rs1;
   assign bus.d2           = use_imm_q ? imm_q : fwd_rs2;
   assign bus.control      = ctrl_q;
   assign bus.ex_pc        = pc_q;
   assign bus.ex_rd        = rd_q;
   assign bus.ex_reg_write = reg_write_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_EMPTY;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      if (bus.flush) begin
         state_d = S_EMPTY;
      end else if (fire_in) begin
         state_d = S_FULL;
         load    = 1'b1;
      end else if (fire_out) begin
         state_d = S_EMPTY;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q        <= '0;
         rs1_data_q  <= '0;
         rs2_data_q  <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         rd_q        <= '0;
         imm_q       <= '0;
         ctrl_q      <= '0;
         use_pc_q    <= 1'b0;
         use_imm_q   <= 1'b0;
         reg_write_q <= 1'b0;
      end else if (load) begin
         pc_q        <= bus.id_pc;
         rs1_data_q  <= bus.id_rs1_data;
         rs2_data_q  <= bus.id_rs2_data;
         rs1_q       <= bus.id_rs1;
         rs2_q       <= bus.id_rs2;
         rd_q        <= bus.id_rd;
         imm_q       <= bus.id_imm;
         ctrl_q      <= bus.id_alu_ctrl;
         use_pc_q    <= bus.id_use_pc;
         use_imm_q   <= bus.id_use_imm;
         reg_write_q <= bus.id_reg_write;
      end else if (full) begin
         // Absorb any producer value seen while stalled so it survives the
         // producer retiring; never absorb a pending load's address.
         if (!(hazard && ld_match_rs1)) rs1_data_q <= fwd_rs1;
         if (!(hazard && ld_match_rs2)) rs2_data_q <= fwd_rs2;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   id_ex_stage_if bus_if ();

   id_ex_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic offer(input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] rs1_data,
                        input logic [4:0] rs2, input logic [31:0] rs2_data, input logic [4:0] rd,
                        input logic [31:0] imm, input logic [3:0] ctrl, input logic use_pc,
                        input logic use_imm);
      bus_if.id_valid     = 1'b1;
      bus_if.id_pc        = pc;
      bus_if.id_rs1       = rs1;
      bus_if.id_rs1_data  = rs1_data;
      bus_if.id_rs2       = rs2;
      bus_if.id_rs2_data  = rs2_data;
      bus_if.id_rd        = rd;
      bus_if.id_imm       = imm;
      bus_if.id_alu_ctrl  = ctrl;
      bus_if.id_use_pc    = use_pc;
      bus_if.id_use_imm   = use_imm;
      bus_if.id_reg_write = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_producers();
      bus_if.exm_reg_write = 1'b0;
      bus_if.exm_rd        = 5'd0;
      bus_if.exm_result    = 32'd0;
      bus_if.exm_is_load   = 1'b0;
      bus_if.wb_reg_write  = 1'b0;
      bus_if.wb_rd         = 5'd0;
      bus_if.wb_data       = 32'd0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      bus_if.id_valid     = 1'b0;
      bus_if.id_pc        = '0;
      bus_if.id_rs1_data  = '0;
      bus_if.id_rs2_data  = '0;
      bus_if.id_rs1       = '0;
      bus_if.id_rs2       = '0;
      bus_if.id_rd        = '0;
      bus_if.id_imm       = '0;
      bus_if.id_alu_ctrl  = '0;
      bus_if.id_use_pc    = 1'b0;
      bus_if.id_use_imm   = 1'b0;
      bus_if.id_reg_write = 1'b0;
      bus_if.flush        = 1'b0;
      bus_if.ex_ready     = 1'b1;
      clear_producers();

      // Reset state
      #2;
      chk("rst_ex_valid", 32'(bus_if.ex_valid), 32'd0);
      chk("rst_d1", bus_if.d1, 32'd0);
      chk("rst_d2", bus_if.d2, 32'd0);
      chk("rst_control", 32'(bus_if.control), 32'd0);
      chk("rst_ex_rd", 32'(bus_if.ex_rd), 32'd0);
      chk("rst_ex_reg_write", 32'(bus_if.ex_reg_write), 32'd0);
      chk("rst_id_ready", 32'(bus_if.id_ready), 32'd1);
      step();
      rst = 1'b0;
      step();

      // Basic ADDI: x2 = x1(5) + 7
      offer(32'h0, 5'd1, 32'd5, 5'd0, 32'd0, 5'd2, 32'd7, 4'b0000, 1'b0, 1'b1);
      step();
      bus_if.id_valid = 1'b0;
      chk("addi_ex_valid", 32'(bus_if.ex_valid), 32'd1);
      chk("addi_d1", bus_if.d1, 32'd5);
      chk("addi_d2", bus_if.d2, 32'd7);
      chk("addi_control", 32'(bus_if.control), 32'd0);
      chk("addi_ex_rd", 32'(bus_if.ex_rd), 32'd2);
      chk("addi_ex_reg_write", 32'(bus_if.ex_reg_write), 32'd1);

      // SUB x8 = x3 - x5, replaces ADDI with no bubble, then stall
      offer(32'h100, 5'd3, 32'd1, 5'd5, 32'd9, 5'd8, 32'd0, 4'b1000, 1'b0, 1'b0);
      step();
      bus_if.id_valid = 1'b0;
      bus_if.ex_ready = 1'b0;
      #1;
      chk("sub_ex_valid", 32'(bus_if.ex_valid), 32'd1);
      chk("sub_control", 32'(bus_if.control), 32'd8);
      chk("sub_ex_pc", bus_if.ex_pc, 32'h100);
      chk("sub_d1_plain", bus_if.d1, 32'd1);
      chk("sub_d2_plain", bus_if.d2, 32'd9);

      // Forward priority on rs1=3
      bus_if.exm_reg_write = 1'b1; bus_if.exm_rd = 5'd3; bus_if.exm_result = 32'hAA;
      bus_if.wb_reg_write  = 1'b1; bus_if.wb_rd  = 5'd3; bus_if.wb_data    = 32'hBB;
      #1;
      chk("fwd_exm_priority", bus_if.d1, 32'hAA);
      chk("fwd_d2_untouched", bus_if.d2, 32'd9);
      bus_if.exm_reg_write = 1'b0;
      #1;
      chk("fwd_wb", bus_if.d1, 32'hBB);
      bus_if.exm_reg_write = 1'b1; bus_if.exm_rd = 5'd0; bus_if.wb_reg_write = 1'b0;
      #1;
      chk("fwd_rd0_none", bus_if.d1, 32'd1);
      bus_if.exm_reg_write = 1'b0;
      bus_if.wb_reg_write  = 1'b1; bus_if.wb_rd = 5'd5; bus_if.wb_data = 32'h77;
      #1;
      chk("fwd_wb_rs2", bus_if.d2, 32'h77);
      chk("fwd_wb_rs2_d1", bus_if.d1, 32'd1);
      clear_producers();
      #1;
      chk("stall_id_ready", 32'(bus_if.id_ready), 32'd0);

      // Load-use on rs2=4
      bus_if.ex_ready = 1'b1;
      offer(32'h200, 5'd1, 32'h10, 5'd4, 32'h20, 5'd6, 32'd0, 4'b0000, 1'b0, 1'b0);
      step();
      bus_if.id_valid = 1'b0;
      bus_if.exm_is_load = 1'b1; bus_if.exm_reg_write = 1'b1;
      bus_if.exm_rd = 5'd4; bus_if.exm_result = 32'hDEAD;
      #1;
      chk("ld_hazard_ex_valid", 32'(bus_if.ex_valid), 32'd0);
      chk("ld_hazard_id_ready", 32'(bus_if.id_ready), 32'd0);
      step();
      chk("ld_hazard_held", 32'(bus_if.ex_valid), 32'd0);
      clear_producers();
      bus_if.wb_reg_write = 1'b1; bus_if.wb_rd = 5'd4; bus_if.wb_data = 32'h1234;
      #1;
      chk("ld_wb_ex_valid", 32'(bus_if.ex_valid), 32'd1);
      chk("ld_wb_d2", bus_if.d2, 32'h1234);
      chk("ld_wb_d1", bus_if.d1, 32'h10);
      step();
      clear_producers();
      #1;
      chk("ld_drain_ex_valid", 32'(bus_if.ex_valid), 32'd0);
      chk("ld_drain_id_ready", 32'(bus_if.id_ready), 32'd1);

      // Load match on rs1 with use_pc: no hazard
      offer(32'h300, 5'd9, 32'h1, 5'd0, 32'h0, 5'd10, 32'h4, 4'b0000, 1'b1, 1'b1);
      step();
      bus_if.id_valid = 1'b0;
      bus_if.ex_ready = 1'b0;
      bus_if.exm_is_load = 1'b1; bus_if.exm_reg_write = 1'b1; bus_if.exm_rd = 5'd9;
      #1;
      chk("ld_use_pc_no_hazard", 32'(bus_if.ex_valid), 32'd1);
      chk("ld_use_pc_d1", bus_if.d1, 32'h300);
      clear_producers();
      bus_if.ex_ready = 1'b1;
      step();

      // Stall refresh: rs1=7, WB supplies 0x55 for one cycle only
      offer(32'h400, 5'd7, 32'h11, 5'd0, 32'h0, 5'd11, 32'h3, 4'b0010, 1'b0, 1'b1);
      step();
      bus_if.ex_ready = 1'b0;
      offer(32'h500, 5'd9, 32'h99, 5'd0, 32'h0, 5'd12, 32'h0, 4'b0011, 1'b0, 1'b1);
      bus_if.wb_reg_write = 1'b1; bus_if.wb_rd = 5'd7; bus_if.wb_data = 32'h55;
      #1;
      chk("refresh_d1_c0", bus_if.d1, 32'h55);
      chk("refresh_id_ready_c0", 32'(bus_if.id_ready), 32'd0);
      step();
      clear_producers();
      #1;
      chk("refresh_d1_c1", bus_if.d1, 32'h55);
      chk("refresh_id_ready_c1", 32'(bus_if.id_ready), 32'd0);
      step();
      chk("refresh_d1_c2", bus_if.d1, 32'h55);
      chk("refresh_id_ready_c2", 32'(bus_if.id_ready), 32'd0);
      chk("refresh_control_kept", 32'(bus_if.control), 32'd2);
      chk("refresh_ex_pc_kept", bus_if.ex_pc, 32'h400);
      chk("refresh_ex_valid", 32'(bus_if.ex_valid), 32'd1);

      // Flush with the offered instruction still present
      bus_if.flush = 1'b1;
      step();
      bus_if.flush = 1'b0;
      bus_if.id_valid = 1'b0;
      chk("flush_ex_valid", 32'(bus_if.ex_valid), 32'd0);
      chk("flush_id_ready", 32'(bus_if.id_ready), 32'd1);
      bus_if.ex_ready = 1'b1;
      step();
      chk("flush_never_presented", 32'(bus_if.ex_valid), 32'd0);

      // Flush while empty and ready: offer not captured
      offer(32'h600, 5'd0, 32'h0, 5'd0, 32'h0, 5'd13, 32'h0, 4'b0101, 1'b0, 1'b1);
      bus_if.flush = 1'b1;
      #1;
      chk("flush_empty_id_ready", 32'(bus_if.id_ready), 32'd1);
      step();
      bus_if.flush = 1'b0;
      bus_if.id_valid = 1'b0;
      #1;
      chk("flush_empty_no_capture", 32'(bus_if.ex_valid), 32'd0);

      // Back-to-back AUIPC-style instructions
      for (int i = 0; i < 4; i++) begin
         offer(32'h1000 + 32'(4 * i), 5'd0, 32'h0, 5'd0, 32'h0, 5'(i + 1),
               32'(16 * i), 4'(i + 1), 1'b1, 1'b1);
         step();
         chk("b2b_ex_valid", 32'(bus_if.ex_valid), 32'd1);
         chk("b2b_d1", bus_if.d1, 32'h1000 + 32'(4 * i));
         chk("b2b_d2", bus_if.d2, 32'(16 * i));
         chk("b2b_control", 32'(bus_if.control), 32'(i + 1));
         chk("b2b_ex_rd", 32'(bus_if.ex_rd), 32'(i + 1));
      end

      // Reset mid-stream
      offer(32'h2000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd20, 32'h0, 4'b0111, 1'b1, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_ex_valid", 32'(bus_if.ex_valid), 32'd0);
      chk("midrst_control", 32'(bus_if.control), 32'd0);
      chk("midrst_d1", bus_if.d1, 32'd0);
      chk("midrst_id_ready", 32'(bus_if.id_ready), 32'd1);
      bus_if.id_valid = 1'b0;
      step();
      rst = 1'b0;
      step();
      chk("postrst_ex_valid", 32'(bus_if.ex_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
